// File: rtl/instruction_decode_unit.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : instruction_decode_unit
// Purpose  : RV32I decode stage with a one-entry skid buffer; halts on an
//            illegal word until the downstream stage flushes it.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_decode_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] instruction_in,
  input  logic [31:0] pc_in,
  input  logic        valid_in,
  input  logic        stall_in,
  input  logic        flush_in,
  output logic        ready_out,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic [2:0]  funct3,
  output logic [3:0]  alu_op,
  output logic [3:0]  op_class,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        use_imm,
  output logic        illegal,
  output logic        halted
);

  localparam logic [3:0] C_ALU_ADD   = 4'd0;
  localparam logic [3:0] C_ALU_SUB   = 4'd1;
  localparam logic [3:0] C_ALU_SLL   = 4'd2;
  localparam logic [3:0] C_ALU_SLT   = 4'd3;
  localparam logic [3:0] C_ALU_SLTU  = 4'd4;
  localparam logic [3:0] C_ALU_XOR   = 4'd5;
  localparam logic [3:0] C_ALU_SRL   = 4'd6;
  localparam logic [3:0] C_ALU_SRA   = 4'd7;
  localparam logic [3:0] C_ALU_OR    = 4'd8;
  localparam logic [3:0] C_ALU_AND   = 4'd9;
  localparam logic [3:0] C_ALU_PASSB = 4'd10;

  localparam logic [3:0] C_CLS_NOP     = 4'd0;
  localparam logic [3:0] C_CLS_OP      = 4'd1;
  localparam logic [3:0] C_CLS_OPIMM   = 4'd2;
  localparam logic [3:0] C_CLS_LOAD    = 4'd3;
  localparam logic [3:0] C_CLS_STORE   = 4'd4;
  localparam logic [3:0] C_CLS_BRANCH  = 4'd5;
  localparam logic [3:0] C_CLS_JAL     = 4'd6;
  localparam logic [3:0] C_CLS_JALR    = 4'd7;
  localparam logic [3:0] C_CLS_LUI     = 4'd8;
  localparam logic [3:0] C_CLS_AUIPC   = 4'd9;
  localparam logic [3:0] C_CLS_SYSTEM  = 4'd10;
  localparam logic [3:0] C_CLS_ILLEGAL = 4'd15;

  localparam logic [6:0] C_OPC_OP     = 7'b0110011;
  localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] C_OPC_FENCE  = 7'b0001111;

  localparam logic [31:0] C_ECALL  = 32'h0000_0073;
  localparam logic [31:0] C_EBREAK = 32'h0010_0073;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic [3:0]  op_class;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        use_imm;
    logic        illegal;
  } dec_t;

  state_e      state_q;
  logic        valid_q;
  dec_t        out_q;
  logic        sb_valid_q;
  logic [31:0] sb_instr_q;
  logic [31:0] sb_pc_q;

  logic        w_adv;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  dec_t        dec_d;

  assign w_adv     = !stall_in || !valid_q;
  assign ready_out = (state_q == ST_RUN) && !sb_valid_q && !stall_in;

  // A held skid entry always takes precedence over the live input.
  assign w_instr = sb_valid_q ? sb_instr_q : instruction_in;
  assign w_pc    = sb_valid_q ? sb_pc_q    : pc_in;

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [3:0]  w_alu_f3;
  logic        w_bad;
  logic [3:0]  w_cls;
  logic [3:0]  w_alu;
  logic [31:0] w_imm;

  assign w_opc   = w_instr[6:0];
  assign w_f3    = w_instr[14:12];
  assign w_f7    = w_instr[31:25];
  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                    w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'b0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                    w_instr[30:21], 1'b0};

  always_comb begin
    w_alu_f3 = C_ALU_AND;
    case (w_f3)
      3'b000:  w_alu_f3 = C_ALU_ADD;
      3'b001:  w_alu_f3 = C_ALU_SLL;
      3'b010:  w_alu_f3 = C_ALU_SLT;
      3'b011:  w_alu_f3 = C_ALU_SLTU;
      3'b100:  w_alu_f3 = C_ALU_XOR;
      3'b101:  w_alu_f3 = C_ALU_SRL;
      3'b110:  w_alu_f3 = C_ALU_OR;
      default: w_alu_f3 = C_ALU_AND;
    endcase
  end

  always_comb begin
    w_bad = 1'b0;
    w_cls = C_CLS_NOP;
    w_alu = C_ALU_ADD;
    w_imm = 32'd0;
    case (w_opc)
      C_OPC_OP: begin
        w_cls = C_CLS_OP;
        w_alu = w_alu_f3;
        if (w_f7 == 7'h20) begin
          if (w_f3 == 3'b000)      w_alu = C_ALU_SUB;
          else if (w_f3 == 3'b101) w_alu = C_ALU_SRA;
          else                     w_bad = 1'b1;
        end else if (w_f7 != 7'h00) begin
          w_bad = 1'b1;
        end
      end
      C_OPC_OPIMM: begin
        w_cls = C_CLS_OPIMM;
        w_imm = w_imm_i;
        w_alu = w_alu_f3;
        // Only the shift encodings constrain the upper immediate bits.
        if (w_f3 == 3'b001 && w_f7 != 7'h00) w_bad = 1'b1;
        if (w_f3 == 3'b101) begin
          if (w_f7 == 7'h20)      w_alu = C_ALU_SRA;
          else if (w_f7 != 7'h00) w_bad = 1'b1;
        end
      end
      C_OPC_LOAD: begin
        w_cls = C_CLS_LOAD;
        w_imm = w_imm_i;
        w_bad = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
      end
      C_OPC_STORE: begin
        w_cls = C_CLS_STORE;
        w_imm = w_imm_s;
        w_bad = (w_f3 > 3'b010);
      end
      C_OPC_BRANCH: begin
        w_cls = C_CLS_BRANCH;
        w_imm = w_imm_b;
        w_bad = (w_f3[2:1] == 2'b01);
      end
      C_OPC_JAL: begin
        w_cls = C_CLS_JAL;
        w_imm = w_imm_j;
      end
      C_OPC_JALR: begin
        w_cls = C_CLS_JALR;
        w_imm = w_imm_i;
        w_bad = (w_f3 != 3'b000);
      end
      C_OPC_LUI: begin
        w_cls = C_CLS_LUI;
        w_imm = w_imm_u;
        w_alu = C_ALU_PASSB;
      end
      C_OPC_AUIPC: begin
        w_cls = C_CLS_AUIPC;
        w_imm = w_imm_u;
      end
      C_OPC_SYSTEM: begin
        w_cls = C_CLS_SYSTEM;
        w_bad = (w_instr != C_ECALL) && (w_instr != C_EBREAK);
      end
      C_OPC_FENCE: begin
        w_cls = C_CLS_NOP;
      end
      default: w_bad = 1'b1;
    endcase
    if (w_instr[1:0] != 2'b11) w_bad = 1'b1;
  end

  always_comb begin
    dec_d           = '0;
    dec_d.pc        = (w_pc - 32'd1) << 2;
    dec_d.instr     = w_instr;
    dec_d.rd        = w_instr[11:7];
    dec_d.rs1       = w_instr[19:15];
    dec_d.rs2       = w_instr[24:20];
    dec_d.funct3    = w_f3;
    dec_d.illegal   = w_bad;
    if (w_bad) begin
      dec_d.op_class = C_CLS_ILLEGAL;
      dec_d.alu_op   = C_ALU_ADD;
      dec_d.imm      = 32'd0;
    end else begin
      dec_d.op_class  = w_cls;
      dec_d.alu_op    = w_alu;
      dec_d.imm       = w_imm;
      dec_d.use_imm   = (w_cls == C_CLS_OPIMM) || (w_cls == C_CLS_LOAD) ||
                        (w_cls == C_CLS_STORE) || (w_cls == C_CLS_JALR) ||
                        (w_cls == C_CLS_LUI)   || (w_cls == C_CLS_AUIPC);
      dec_d.reg_write = ((w_cls == C_CLS_OP)   || (w_cls == C_CLS_OPIMM) ||
                         (w_cls == C_CLS_LOAD) || (w_cls == C_CLS_JAL)   ||
                         (w_cls == C_CLS_JALR) || (w_cls == C_CLS_LUI)   ||
                         (w_cls == C_CLS_AUIPC)) && (w_instr[11:7] != 5'd0);
      dec_d.mem_read  = (w_cls == C_CLS_LOAD);
      dec_d.mem_write = (w_cls == C_CLS_STORE);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_RUN;
      valid_q    <= 1'b0;
      out_q      <= '0;
      sb_valid_q <= 1'b0;
      sb_instr_q <= 32'd0;
      sb_pc_q    <= 32'd0;
    end else if (flush_in) begin
      state_q    <= ST_RUN;
      valid_q    <= 1'b0;
      sb_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (w_adv) begin
            if (sb_valid_q || valid_in) begin
              valid_q    <= 1'b1;
              out_q      <= dec_d;
              sb_valid_q <= 1'b0;
              if (dec_d.illegal) state_q <= ST_HALTED;
            end else begin
              valid_q <= 1'b0;
            end
          end else if (valid_in && !sb_valid_q) begin
            sb_valid_q <= 1'b1;
            sb_instr_q <= instruction_in;
            sb_pc_q    <= pc_in;
          end
        end
        ST_HALTED: begin
          // The illegal entry stays visible until it is consumed or flushed.
          sb_valid_q <= 1'b0;
          if (w_adv) valid_q <= 1'b0;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign valid_out = valid_q;
  assign pc_out    = out_q.pc;
  assign instr_out = out_q.instr;
  assign rd        = out_q.rd;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign imm       = out_q.imm;
  assign funct3    = out_q.funct3;
  assign alu_op    = out_q.alu_op;
  assign op_class  = out_q.op_class;
  assign reg_write = out_q.reg_write;
  assign mem_read  = out_q.mem_read;
  assign mem_write = out_q.mem_write;
  assign use_imm   = out_q.use_imm;
  assign illegal   = out_q.illegal;
  assign halted    = (state_q == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode_unit.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_instruction_decode_unit
// Purpose  : Scoreboarded random and directed bench for the RV32I decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_decode_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] instruction_in = '0;
  logic [31:0] pc_in = '0;
  logic        valid_in = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic        ready_out, valid_out;
  logic [31:0] pc_out, instr_out, imm;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [3:0]  alu_op, op_class;
  logic        reg_write, mem_read, mem_write, use_imm, illegal, halted;

  always #5 clk = ~clk;

  instruction_decode_unit dut (
    .clk(clk), .resetn(resetn), .instruction_in(instruction_in), .pc_in(pc_in),
    .valid_in(valid_in), .stall_in(stall_in), .flush_in(flush_in),
    .ready_out(ready_out), .valid_out(valid_out), .pc_out(pc_out),
    .instr_out(instr_out), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .funct3(funct3), .alu_op(alu_op), .op_class(op_class),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .use_imm(use_imm), .illegal(illegal), .halted(halted)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [3:0]  alu, cls;
    logic        rw, mr, mw, ui, ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   halted_model = 1'b0;

  function automatic void chk(input string name, input logic [159:0] got,
                              input logic [159:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endfunction

  function automatic logic [3:0] alu_for(input logic [2:0] f3, input bit alt);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (alt) return (f3 == 3'd0) ? 4'd1 : 4'd7;
    return tbl[f3];
  endfunction

  // Reference decode built from the ISA field definitions with plain arithmetic.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] p);
    exp_t e;
    logic signed [31:0] sx;
    int  hi, ii, s7;
    int  f3, f7;
    bit  ok;
    sx = w;
    hi = sx >>> 31;
    ii = sx >>> 20;
    s7 = sx >>> 25;
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    e = '0;
    e.pc = (p - 32'd1) * 32'd4;
    e.instr = w;
    e.rd = w[11:7];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.f3 = w[14:12];
    ok = 1'b1;
    case (w[6:0])
      7'h33: begin
        e.cls = 4'd1;
        if (f7 == 0) e.alu = alu_for(w[14:12], 1'b0);
        else if (f7 == 32 && (f3 == 0 || f3 == 5)) e.alu = alu_for(w[14:12], 1'b1);
        else ok = 1'b0;
      end
      7'h13: begin
        e.cls = 4'd2;
        e.imm = ii;
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0) || (f7 == 32);
        e.alu = alu_for(w[14:12], (f3 == 5) && (f7 == 32));
      end
      7'h03: begin e.cls = 4'd3; e.imm = ii; ok = f3 inside {0, 1, 2, 4, 5}; end
      7'h23: begin e.cls = 4'd4; e.imm = s7 * 32 + int'(w[11:7]); ok = (f3 <= 2); end
      7'h63: begin
        e.cls = 4'd5;
        e.imm = hi * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        ok = !(f3 inside {2, 3});
      end
      7'h6F: begin
        e.cls = 4'd6;
        e.imm = hi * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      end
      7'h67: begin e.cls = 4'd7; e.imm = ii; ok = (f3 == 0); end
      7'h37: begin e.cls = 4'd8; e.imm = w & 32'hFFFF_F000; e.alu = 4'd10; end
      7'h17: begin e.cls = 4'd9; e.imm = w & 32'hFFFF_F000; end
      7'h73: begin e.cls = 4'd10; ok = (w == 32'h73) || (w == 32'h0010_0073); end
      7'h0F: e.cls = 4'd0;
      default: ok = 1'b0;
    endcase
    if (ok) begin
      e.ui = e.cls inside {4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9};
      e.rw = (e.cls inside {4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9}) && (e.rd != 0);
      e.mr = (e.cls == 4'd3);
      e.mw = (e.cls == 4'd4);
    end else begin
      e.cls = 4'd15; e.ill = 1'b1; e.alu = 4'd0; e.imm = 32'd0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11];
    logic [31:0] w;
    int r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
    w = $urandom();
    r = $urandom_range(0, 99);
    if (r < 5) return w;
    if (r < 8) return (r == 5) ? 32'h0000_0073 : 32'h0010_0073;
    w[6:0] = ops[$urandom_range(0, 10)];
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
      case ($urandom_range(0, 9))
        0, 1:    w[31:25] = 7'h20;
        2:       ;
        default: w[31:25] = 7'h00;
      endcase
    end
    return w;
  endfunction

  function automatic logic [128:0] snap();
    return {valid_out, pc_out, instr_out, rd, rs1, rs2, imm, funct3, alu_op,
            op_class, reg_write, mem_read, mem_write, use_imm, illegal, halted};
  endfunction

  task automatic drive(input logic [31:0] w, input logic [31:0] p, input bit push);
    instruction_in = w;
    pc_in = p;
    valid_in = 1'b1;
    if (push) exp_q.push_back(model(w, p));
  endtask

  // Monitor: pops one expected entry per accepted output beat.
  logic [128:0] snap_q;
  bit           hold_v = 1'b0;
  exp_t         me;
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_q.delete();
        hold_v = 1'b0;
      end else begin
        if (hold_v) chk("stall_hold", snap(), snap_q);
        if (valid_out && !stall_in) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_output: instr %h pc %h with nothing expected", instr_out, pc_out);
          end else begin
            me = exp_q.pop_front();
            chk("pc_out", pc_out, me.pc);
            chk("instr_out", instr_out, me.instr);
            chk("op_class", op_class, me.cls);
            chk("illegal", illegal, me.ill);
            chk("ctrl", {reg_write, mem_read, mem_write, use_imm}, {me.rw, me.mr, me.mw, me.ui});
            chk("funct3", funct3, me.f3);
            if (!me.ill) begin
              chk("regs", {rd, rs1, rs2}, {me.rd, me.rs1, me.rs2});
              chk("imm", imm, me.imm);
              chk("alu_op", alu_op, me.alu);
            end
          end
        end
        hold_v = valid_out && stall_in && !flush_in;
        snap_q = snap();
        if (flush_in) exp_q.delete();
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  bit prev_ready;
  bit vin, fl;
  exp_t de;
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", snap(), 129'd0);
    chk("reset_ready", ready_out, 1'b1);
    stall_in = 1'b1;
    #1 chk("reset_ready_stalled", ready_out, 1'b0);
    stall_in = 1'b0;
    resetn = 1'b1;

    // ADDI x1, x0, 5 at word index 0
    @(posedge clk); #1 drive(32'h0050_0093, 32'd1, 1'b1);
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk);
    chk("addi_valid", valid_out, 1'b1);
    chk("addi_fields", {op_class, rd, rs1, imm, alu_op, use_imm, reg_write, pc_out},
        {4'd2, 5'd1, 5'd0, 32'd5, 4'd0, 1'b1, 1'b1, 32'd0});

    @(posedge clk); #1 drive(32'hFE20_8EE3, 32'd5, 1'b1);
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk);
    chk("beq_fields", {op_class, rs1, rs2, imm, reg_write, pc_out},
        {4'd5, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 32'd16});

    @(posedge clk); #1 drive(32'h4020_81B3, 32'd8, 1'b1);
    @(posedge clk); #1 drive(32'h1234_52B7, 32'd9, 1'b1);
    @(negedge clk);
    chk("sub_fields", {alu_op, rd, op_class}, {4'd1, 5'd3, 4'd1});
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk);
    chk("lui_fields", {imm, alu_op, rd, valid_out}, {32'h1234_5000, 4'd10, 5'd5, 1'b1});

    // Stall with a second word landing in the skid buffer
    @(posedge clk); #1 drive(32'h00A0_0113, 32'd20, 1'b1);
    @(posedge clk); #1 drive(32'h0030_8193, 32'd21, 1'b1); stall_in = 1'b1;
    #1 chk("skid_ready_t1", ready_out, 1'b0);
    @(negedge clk); chk("skid_hold_t1", {valid_out, instr_out}, {1'b1, 32'h00A0_0113});
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk); chk("skid_hold_t2", {valid_out, instr_out, ready_out}, {1'b1, 32'h00A0_0113, 1'b0});
    @(posedge clk);
    @(negedge clk); chk("skid_hold_t3", {valid_out, instr_out, ready_out}, {1'b1, 32'h00A0_0113, 1'b0});
    @(posedge clk); #1 stall_in = 1'b0;
    @(negedge clk); chk("skid_release", {valid_out, instr_out}, {1'b1, 32'h00A0_0113});
    @(posedge clk);
    @(negedge clk); chk("skid_b_out", {valid_out, instr_out, pc_out}, {1'b1, 32'h0030_8193, 32'd80});
    @(posedge clk);
    @(negedge clk); chk("skid_b_once", valid_out, 1'b0);

    // Illegal word halts; later inputs are discarded until flush
    @(posedge clk); #1 drive(32'h0000_0000, 32'd30, 1'b1);
    @(posedge clk); #1 drive(32'h0050_0093, 32'd31, 1'b0);
    @(negedge clk);
    chk("illegal_fields", {valid_out, illegal, op_class, halted}, {1'b1, 1'b1, 4'd15, 1'b1});
    @(posedge clk); #1 drive(32'h0050_0093, 32'd32, 1'b0);
    @(negedge clk); chk("halted_drop", {valid_out, halted, ready_out}, {1'b0, 1'b1, 1'b0});
    @(posedge clk); #1 valid_in = 1'b0; flush_in = 1'b1;
    @(posedge clk); #1 flush_in = 1'b0;
    @(negedge clk); chk("flush_exit", {halted, valid_out, ready_out}, {1'b0, 1'b0, 1'b1});

    // Reset while stalled with the skid buffer occupied
    @(posedge clk); #1 drive(32'h0010_0093, 32'd40, 1'b1);
    @(posedge clk); #1 drive(32'h0020_0113, 32'd41, 1'b1); stall_in = 1'b1;
    @(posedge clk); #1 valid_in = 1'b0; resetn = 1'b0;
    @(posedge clk); #1;
    chk("midreset_outputs", snap(), 129'd0);
    chk("midreset_ready", ready_out, 1'b0);
    stall_in = 1'b0;
    #1 chk("midreset_ready_unstalled", ready_out, 1'b1);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("midreset_no_output", valid_out, 1'b0);

    // Randomized protocol-compliant traffic
    halted_model = 1'b0;
    prev_ready = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      fl  = halted_model && ($urandom_range(0, 3) == 0);
      vin = prev_ready && ($urandom_range(0, 3) != 0);
      stall_in = ($urandom_range(0, 3) == 0);
      flush_in = fl;
      instruction_in = rand_instr();
      pc_in = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom();
      valid_in = vin;
      if (vin && !fl && !halted_model) begin
        de = model(instruction_in, pc_in);
        exp_q.push_back(de);
        if (de.ill) halted_model = 1'b1;
      end
      if (fl) halted_model = 1'b0;
      #1 prev_ready = ready_out;
    end

    @(posedge clk); #1 valid_in = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
    repeat (6) @(posedge clk);
    #1 flush_in = halted_model;
    halted_model = 1'b0;
    @(posedge clk); #1 flush_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) chk("drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
